latch_bank_write_ctrl: RTL and testbench

Synchronous write sequencer that drives a bank of WAY parallel transparent latches, each WIRE bits wide, with per-way enable and per-way reset. It accepts single-word write or clear requests on a valid/ready handshake. It then produces glitch-free, setup/hold-safe enable (`lat_en`) and reset (`lat_rst`) pulses plus the data bus (`lat_d`) for the latch bank directly downstream. All outputs are registered, so the latch gates are driven only from flops.

---
 rtl/latch_bank_write_ctrl_pkg.sv | 23 ++
 rtl/latch_bank_write_ctrl_if.sv | 37 +++
 rtl/latch_bank_write_ctrl_pulse_counter.sv | 31 +++
 rtl/latch_bank_write_ctrl.sv | 138 +++++++++++++
 tb/tb_latch_bank_write_ctrl.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/latch_bank_write_ctrl_pkg.sv
// Shared definitions for the latch bank write controller.
//   state_e : sequencer states, IDLE -> SETUP -> PULSE -> HOLD
//   op_e    : captured operation, write data or clear lane(s)
//   idx_width() : width of a lane index, never below 1 bit
package latch_bank_write_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PULSE = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_CLR   = 1'b1
  } op_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/latch_bank_write_ctrl_if.sv
// Request / latch-bank bus of the latch bank write controller.
//   master : request source (req_valid, req_way, req_data, req_clr, clr_all)
//            and observer of status and latch drive signals
//   slave  : the controller
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is registered and never depends on
// req_valid in the same cycle. clr_all needs no valid, it is taken on any
// edge where req_ready is 1 and wins over a simultaneous req_valid.
interface latch_bank_write_ctrl_if
  import latch_bank_write_ctrl_pkg::*;
#(
  parameter int WAY  = 3,
  parameter int WIRE = 8,
  parameter int IW   = idx_width(WAY)
);
  logic                  req_valid;
  logic                  req_ready;
  logic [IW-1:0]         req_way;
  logic [WIRE-1:0]       req_data;
  logic                  req_clr;
  logic                  clr_all;
  logic                  done;
  logic                  err;
  logic [WAY*WIRE-1:0]   lat_d;
  logic [WAY-1:0]        lat_en;
  logic [WAY-1:0]        lat_rst;

  modport master (
    output req_valid, req_way, req_data, req_clr, clr_all,
    input  req_ready, done, err, lat_d, lat_en, lat_rst
  );

  modport slave (
    input  req_valid, req_way, req_data, req_clr, clr_all,
    output req_ready, done, err, lat_d, lat_en, lat_rst
  );
endinterface

// File: rtl/latch_bank_write_ctrl_pulse_counter.sv
// Loadable down-counter timing the PULSE phase.
//   clk, rst  : clock, synchronous active-high reset
//   load_i    : load load_val_i (wins over dec_i)
//   dec_i     : decrement, saturating at zero
//   load_val_i: value to load
//   zero_o    : count is zero
module latch_bank_write_ctrl_pulse_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                   cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/latch_bank_write_ctrl.sv
// Write sequencer for a bank of WAY transparent latches, WIRE bits each.
// Each accepted request runs SETUP (data bus update), PULSE (PULSE_LEN
// cycles of lat_en or lat_rst on the target lanes) and HOLD (done). Every
// latch-facing output comes straight from a flop, one cycle behind the
// state that produced it, so lat_d settles a cycle before a gate opens and
// stays put a cycle after it closes.
//   clk, rst    : clock, synchronous active-high reset
//   bus (slave) : request handshake, status pulses, latch drive
//   dbg_state_o : current sequencer state
module latch_bank_write_ctrl
  import latch_bank_write_ctrl_pkg::*;
#(
  parameter int WAY       = 3,
  parameter int WIRE      = 8,
  parameter int PULSE_LEN = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  latch_bank_write_ctrl_if.slave bus,
  output state_e                 dbg_state_o
);
  localparam int IW = idx_width(WAY);
  localparam int CW = $clog2(PULSE_LEN + 1);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [WAY-1:0]       mask_q, mask_d;
  logic [WIRE-1:0]      data_q, data_d;
  logic                 oor_q, oor_d;
  logic                 ready_q, ready_d;
  logic [WAY*WIRE-1:0]  lat_d_q, lat_d_d;
  logic [WAY-1:0]       lat_en_q, lat_en_d;
  logic [WAY-1:0]       lat_rst_q, lat_rst_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [WAY-1:0]       way_mask;
  logic                 cnt_zero;

  // One-hot lane decode; an out-of-range index matches no lane.
  always_comb begin
    way_mask = '0;
    for (int i = 0; i < WAY; i++) way_mask[i] = (bus.req_way == IW'(i));
  end

  // Loaded with PULSE_LEN-1 while in SETUP so PULSE lasts PULSE_LEN cycles.
  latch_bank_write_ctrl_pulse_counter #(.W(CW)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == S_SETUP),
    .dec_i      (state_q == S_PULSE),
    .load_val_i (CW'(PULSE_LEN - 1)),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mask_d    = mask_q;
    data_d    = data_q;
    oor_d     = oor_q;
    lat_d_d   = lat_d_q;
    lat_en_d  = '0;
    lat_rst_d = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // ready_q is low for one cycle after reset and after HOLD.
        if (ready_q) begin
          if (bus.clr_all) begin
            op_d    = OP_CLR;
            mask_d  = '1;
            oor_d   = 1'b0;
            state_d = S_SETUP;
          end else if (bus.req_valid) begin
            op_d    = bus.req_clr ? OP_CLR : OP_WRITE;
            mask_d  = way_mask;
            data_d  = bus.req_data;
            oor_d   = ~|way_mask;
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        for (int i = 0; i < WAY; i++)
          if (mask_q[i]) lat_d_d[i*WIRE +: WIRE] = (op_q == OP_CLR) ? '0 : data_q;
        state_d = S_PULSE;
      end
      S_PULSE: begin
        if (op_q == OP_WRITE) lat_en_d  = mask_q;
        else                  lat_rst_d = mask_q;
        if (cnt_zero) state_d = S_HOLD;
      end
      default: begin
        done_d  = 1'b1;
        err_d   = oor_q;
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_WRITE;
      mask_q    <= '0;
      data_q    <= '0;
      oor_q     <= 1'b0;
      ready_q   <= 1'b0;
      lat_d_q   <= '0;
      lat_en_q  <= '0;
      lat_rst_q <= '1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      mask_q    <= mask_d;
      data_q    <= data_d;
      oor_q     <= oor_d;
      ready_q   <= ready_d;
      lat_d_q   <= lat_d_d;
      lat_en_q  <= lat_en_d;
      lat_rst_q <= lat_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.lat_d     = lat_d_q;
  assign bus.lat_en    = lat_en_q;
  assign bus.lat_rst   = lat_rst_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_latch_bank_write_ctrl.sv
module tb_latch_bank_write_ctrl;
  import latch_bank_write_ctrl_pkg::*;

  localparam int WAY  = 3;
  localparam int WIRE = 8;
  localparam int PL   = 2;
  localparam int IW   = 2;
  localparam int LW   = WAY * WIRE;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_e dbg_state;
  int     checks = 0;
  int     errors = 0;

  logic [WIRE-1:0] model_lane [WAY];

  latch_bank_write_ctrl_if #(.WAY(WAY), .WIRE(WIRE)) bus ();

  latch_bank_write_ctrl #(.WAY(WAY), .WIRE(WIRE), .PULSE_LEN(PL)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] pack_model();
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < WAY; i++) v[i*WIRE +: WIRE] = model_lane[i];
    return v;
  endfunction

  // Waits (bounded) for req_ready at a falling edge, drives the request and
  // returns just after the accepting rising edge.
  task automatic issue(input bit ca, input bit v, input int way,
                       input logic [WIRE-1:0] data, input bit clr, input bit keep_valid);
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check("req_ready_timeout", {31'd0, bus.req_ready}, 32'd1);
    bus.clr_all   = ca;
    bus.req_valid = v;
    bus.req_way   = IW'(way);
    bus.req_data  = data;
    bus.req_clr   = clr;
    @(posedge clk);
    #1;
    bus.clr_all = 1'b0;
    if (!keep_valid) bus.req_valid = 1'b0;
  endtask

  // Checks every output after edges E .. E+PL+3 following the accept edge E.
  task automatic run_timeline(input logic [LW-1:0] old_d, input logic [LW-1:0] new_d,
                              input logic [WAY-1:0] mask, input bit is_clr, input bit oor);
    logic [WAY-1:0] pulse;
    for (int k = 0; k <= PL + 3; k++) begin
      @(negedge clk);
      pulse = (k >= 2 && k <= PL + 1) ? mask : '0;
      check($sformatf("lat_d k=%0d", k), 32'(bus.lat_d), 32'((k == 0) ? old_d : new_d));
      check($sformatf("lat_en k=%0d", k), 32'(bus.lat_en), 32'(is_clr ? '0 : pulse));
      check($sformatf("lat_rst k=%0d", k), 32'(bus.lat_rst), 32'(is_clr ? pulse : '0));
      check($sformatf("done k=%0d", k), {31'd0, bus.done}, {31'd0, k == PL + 2});
      check($sformatf("err k=%0d", k), {31'd0, bus.err}, {31'd0, (k == PL + 2) && oor});
      check($sformatf("req_ready k=%0d", k), {31'd0, bus.req_ready}, {31'd0, k == PL + 3});
    end
  endtask

  // Full operation: reference model update, issue, timeline check.
  task automatic do_op(input bit ca, input int way, input logic [WIRE-1:0] data,
                       input bit clr, input bit keep_valid);
    logic [LW-1:0]  old_d;
    logic [WAY-1:0] mask;
    bit             oor;
    old_d = pack_model();
    oor   = !ca && (way >= WAY);
    mask  = ca ? '1 : (oor ? '0 : WAY'(1 << way));
    for (int i = 0; i < WAY; i++)
      if (mask[i]) model_lane[i] = (ca || clr) ? '0 : data;
    issue(ca, !ca || keep_valid, way, data, clr, keep_valid);
    run_timeline(old_d, pack_model(), mask, ca || clr, oor);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_way   = '0;
    bus.req_data  = '0;
    bus.req_clr   = 1'b0;
    bus.clr_all   = 1'b0;
    for (int i = 0; i < WAY; i++) model_lane[i] = '0;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst lat_rst", 32'(bus.lat_rst), 32'h7);
    check("rst lat_en", 32'(bus.lat_en), 32'h0);
    check("rst lat_d", 32'(bus.lat_d), 32'h0);
    check("rst req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst lat_rst", 32'(bus.lat_rst), 32'h0);
    check("post-rst req_ready", {31'd0, bus.req_ready}, 32'd1);

    // Directed operations
    do_op(1'b0, 1, 8'hA5, 1'b0, 1'b0);
    do_op(1'b0, 2, 8'hFF, 1'b0, 1'b0);
    do_op(1'b0, 2, 8'h00, 1'b1, 1'b0);
    do_op(1'b0, 0, 8'h11, 1'b0, 1'b0);
    // clr_all together with a pending write; valid stays up throughout
    do_op(1'b1, 0, 8'h3C, 1'b0, 1'b1);
    do_op(1'b0, 0, 8'h3C, 1'b0, 1'b0);
    // Out-of-range lane
    do_op(1'b0, 3, 8'h77, 1'b0, 1'b0);

    // Reset in the middle of a pulse
    issue(1'b0, 1'b1, 1, 8'h5A, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("midop lat_en", 32'(bus.lat_en), 32'h2);
    rst = 1'b1;
    @(negedge clk);
    check("midop-rst lat_en", 32'(bus.lat_en), 32'h0);
    check("midop-rst lat_rst", 32'(bus.lat_rst), 32'h7);
    check("midop-rst done", {31'd0, bus.done}, 32'd0);
    check("midop-rst req_ready", {31'd0, bus.req_ready}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < WAY; i++) model_lane[i] = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("after-abort done k=%0d", k), {31'd0, bus.done}, 32'd0);
      check($sformatf("after-abort req_ready k=%0d", k), {31'd0, bus.req_ready}, 32'd1);
      check($sformatf("after-abort lat_rst k=%0d", k), 32'(bus.lat_rst), 32'h0);
      check($sformatf("after-abort lat_d k=%0d", k), 32'(bus.lat_d), 32'(pack_model()));
    end

    // Random operations against the reference model
    for (int n = 0; n < 40; n++) begin
      do_op($urandom_range(0, 7) == 0, int'($urandom_range(0, 3)),
            WIRE'($urandom_range(0, 255)), $urandom_range(0, 3) == 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
